// File: rtl/branch_defs_pkg.sv
// Shared branch definitions: funct3 codes, 2-bit counter encodings, controller states
// and small decode helpers used by the controller and the BHT.
package branch_defs;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // funct3 010 and 011 do not encode a conditional branch
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic taken;
        taken = 1'b0;
        case (f3)
            BEQ:         taken = eq;
            BNE:         taken = !eq;
            BLT, BLTU:   taken = lt;
            BGE, BGEU:   taken = !lt;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != ST)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != SNT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: asynchronous read port,
// synchronous saturating update port. A same-index read sees the pre-update value.
module bht_2bit
    import branch_defs::*;
#(
    parameter int BHT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                wr_en,
    input  logic [BHT_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0] ctr [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= WNT;
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        end
    end

    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: IF-stage BHT prediction, EX-stage resolution, mispredict
// redirect and multi-cycle flush, plus branch/mispredict statistics counters.
module branch_ctrl
    import branch_defs::*;
#(
    parameter int BHT_BITS     = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        br_un,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    input  logic        cnt_clr,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FCNT_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);

    state_t        state, state_next;
    logic [FW-1:0] fcnt, fcnt_next;

    logic       actual_taken;
    logic       resolve;
    logic       mispredict;
    logic [1:0] if_ctr;

    assign br_un        = (ex_funct3 == BLTU) || (ex_funct3 == BGEU);
    assign actual_taken = f3_taken(ex_funct3, br_eq, br_lt);

    // An EX branch is consumed only in a cycle where ex_valid is high, stall is low
    // and no flush window is open; there is no backpressure toward EX beyond stall.
    assign resolve    = ex_valid && ex_is_branch && f3_legal(ex_funct3) && !stall
                        && (state == IDLE);
    assign mispredict = resolve && (actual_taken != ex_pred_taken);

    assign redirect    = mispredict;
    assign redirect_pc = actual_taken ? ex_target : ex_pc + 32'd4;
    assign flush       = mispredict || (state == FLUSH);

    // fcnt holds the flush cycles still owed after the mispredict cycle itself,
    // including the current FLUSH cycle, so the window totals FLUSH_CYCLES.
    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        case (state)
            IDLE: begin
                if (mispredict && FLUSH_CYCLES > 1) begin
                    state_next = FLUSH;
                    fcnt_next  = FCNT_LOAD;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    fcnt_next = fcnt - FCNT_ONE;
                    if (fcnt == FCNT_ONE)
                        state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                fcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve)
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    bht_2bit #(
        .BHT_BITS(BHT_BITS)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[BHT_BITS+1:2]),
        .rd_ctr   (if_ctr),
        .wr_en    (resolve),
        .wr_idx   (ex_pc[BHT_BITS+1:2]),
        .wr_taken (actual_taken)
    );

    assign if_pred_taken = if_ctr[1];

    logic unused_bits;
    assign unused_bits = ^{if_pc[31:BHT_BITS+2], if_pc[1:0], if_ctr[0]};

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: drivers push expected outputs tagged with the cycle
// they apply to; a negedge monitor pops and compares every entry due that cycle.
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        br_eq;
    logic        br_lt;
    logic        br_un;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        cnt_clr;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_ctrl #(
        .BHT_BITS     (6),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .br_eq         (br_eq),
        .br_lt         (br_lt),
        .br_un         (br_un),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .cnt_clr       (cnt_clr),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    localparam int W = 52;  // {cycle[15:0], kind[3:0], value[31:0]}
    localparam int K_PRED = 0, K_BRUN = 1, K_REDIR = 2, K_RPC = 3,
                   K_FLUSH = 4, K_BCNT = 5, K_MCNT = 6;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic string kname(input int k);
        case (k)
            K_PRED:  return "if_pred_taken";
            K_BRUN:  return "br_un";
            K_REDIR: return "redirect";
            K_RPC:   return "redirect_pc";
            K_FLUSH: return "flush";
            K_BCNT:  return "branch_cnt";
            K_MCNT:  return "mispred_cnt";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_PRED:  return {31'd0, if_pred_taken};
            K_BRUN:  return {31'd0, br_un};
            K_REDIR: return {31'd0, redirect};
            K_RPC:   return redirect_pc;
            K_FLUSH: return {31'd0, flush};
            K_BCNT:  return branch_cnt;
            K_MCNT:  return mispred_cnt;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic expect_at(input int k, input logic [31:0] v, input int ofs);
        logic [W-1:0] e;
        e = {16'(cyc + ofs), 4'(k), v};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        int i;
        logic [W-1:0] e;
        logic [31:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            e = exp_q[i];
            if (e[51:36] == 16'(cyc)) begin
                act = actual(int'(e[35:32]));
                n_checks++;
                if (act !== e[31:0]) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d: got %h, expected %h",
                             kname(int'(e[35:32])), cyc, act, e[31:0]);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    // ---------------- drivers ----------------
    task step;
        @(posedge clk);
        #1;
    endtask

    task idle;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_funct3     = 3'b000;
        ex_pc         = 32'h0;
        ex_target     = 32'h0;
        ex_pred_taken = 1'b0;
        br_eq         = 1'b0;
        br_lt         = 1'b0;
        stall         = 1'b0;
        cnt_clr       = 1'b0;
    endtask

    task br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
            input logic pred, input logic eq, input logic lt);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        br_eq         = eq;
        br_lt         = lt;
        stall         = 1'b0;
        cnt_clr       = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        if_pc = 32'h100;
        idle();
        step();
        step();

        // Reset state
        rst = 1'b0;
        expect_at(K_PRED, 0, 0);
        expect_at(K_FLUSH, 0, 0);
        expect_at(K_REDIR, 0, 0);
        expect_at(K_BRUN, 0, 0);
        expect_at(K_BCNT, 0, 0);
        expect_at(K_MCNT, 0, 0);

        // BLTU taken, predicted not-taken
        step();
        br(3'b110, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
        expect_at(K_BRUN, 1, 0);
        expect_at(K_REDIR, 1, 0);
        expect_at(K_RPC, 32'h200, 0);
        expect_at(K_FLUSH, 1, 0);
        expect_at(K_PRED, 0, 0);
        expect_at(K_BCNT, 1, 1);
        expect_at(K_MCNT, 1, 1);
        expect_at(K_PRED, 1, 1);
        expect_at(K_FLUSH, 1, 1);
        step();
        idle();
        expect_at(K_REDIR, 0, 0);
        step();
        expect_at(K_FLUSH, 0, 0);

        // Same PC, BEQ taken three times: counter saturates at 11
        for (int n = 0; n < 3; n++) begin
            step();
            br(3'b000, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0);
            expect_at(K_REDIR, 0, 0);
            expect_at(K_FLUSH, 0, 0);
        end
        expect_at(K_BCNT, 4, 1);
        expect_at(K_MCNT, 1, 1);
        // One not-taken: 11 -> 10, still predicts taken
        step();
        br(3'b000, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
        expect_at(K_REDIR, 1, 0);
        expect_at(K_RPC, 32'h104, 0);
        expect_at(K_FLUSH, 1, 0);
        expect_at(K_PRED, 1, 1);
        expect_at(K_BCNT, 5, 1);
        expect_at(K_MCNT, 2, 1);
        expect_at(K_FLUSH, 1, 1);
        step();
        idle();
        step();
        expect_at(K_FLUSH, 0, 0);

        // BNE not taken, predicted taken; next branch lands in FLUSH and is ignored
        step();
        br(3'b001, 32'h3C, 32'h80, 1'b1, 1'b1, 1'b0);
        expect_at(K_REDIR, 1, 0);
        expect_at(K_RPC, 32'h40, 0);
        expect_at(K_FLUSH, 1, 0);
        step();
        br(3'b000, 32'h50, 32'h90, 1'b0, 1'b1, 1'b0);
        expect_at(K_REDIR, 0, 0);
        expect_at(K_FLUSH, 1, 0);
        expect_at(K_BCNT, 6, 1);
        expect_at(K_MCNT, 3, 1);
        expect_at(K_FLUSH, 0, 1);
        step();
        idle();

        // Stalled mispredicting BGE, then stall inside FLUSH
        if_pc = 32'h208;
        step();
        br(3'b101, 32'h208, 32'h300, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        expect_at(K_REDIR, 0, 0);
        expect_at(K_FLUSH, 0, 0);
        expect_at(K_PRED, 0, 0);
        step();
        expect_at(K_REDIR, 0, 0);
        expect_at(K_FLUSH, 0, 0);
        expect_at(K_BCNT, 6, 1);
        expect_at(K_MCNT, 3, 1);
        expect_at(K_PRED, 0, 1);
        step();
        stall = 1'b0;
        expect_at(K_REDIR, 1, 0);
        expect_at(K_RPC, 32'h300, 0);
        expect_at(K_FLUSH, 1, 0);
        step();
        idle();
        stall = 1'b1;
        expect_at(K_FLUSH, 1, 0);
        step();
        expect_at(K_FLUSH, 1, 0);
        step();
        stall = 1'b0;
        expect_at(K_FLUSH, 1, 0);
        expect_at(K_BCNT, 7, 0);
        expect_at(K_MCNT, 4, 0);
        expect_at(K_PRED, 1, 0);
        step();
        expect_at(K_FLUSH, 0, 0);

        // Illegal funct3 is not a branch
        step();
        br(3'b010, 32'h20, 32'h60, 1'b1, 1'b0, 1'b0);
        expect_at(K_REDIR, 0, 0);
        expect_at(K_FLUSH, 0, 0);
        expect_at(K_BRUN, 0, 0);
        expect_at(K_BCNT, 7, 1);
        expect_at(K_MCNT, 4, 1);

        // cnt_clr wins over a coincident resolve
        step();
        br(3'b111, 32'h10C, 32'h180, 1'b1, 1'b0, 1'b0);
        cnt_clr = 1'b1;
        expect_at(K_BRUN, 1, 0);
        expect_at(K_REDIR, 0, 0);
        expect_at(K_FLUSH, 0, 0);
        expect_at(K_BCNT, 0, 1);
        expect_at(K_MCNT, 0, 1);

        // Fall-through PC wraps at the top of the address space
        step();
        br(3'b000, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0);
        expect_at(K_REDIR, 1, 0);
        expect_at(K_RPC, 32'h0, 0);
        expect_at(K_FLUSH, 1, 0);
        step();
        idle();
        expect_at(K_FLUSH, 1, 0);
        step();
        expect_at(K_FLUSH, 0, 0);
        expect_at(K_BCNT, 1, 0);
        expect_at(K_MCNT, 1, 0);

        // Reset asserted during FLUSH
        step();
        br(3'b100, 32'h400, 32'h500, 1'b0, 1'b0, 1'b1);
        expect_at(K_REDIR, 1, 0);
        expect_at(K_RPC, 32'h500, 0);
        expect_at(K_FLUSH, 1, 0);
        step();
        idle();
        rst = 1'b1;
        expect_at(K_FLUSH, 1, 0);
        expect_at(K_BCNT, 2, 0);
        expect_at(K_MCNT, 2, 0);
        step();
        rst = 1'b0;
        expect_at(K_FLUSH, 0, 0);
        expect_at(K_BCNT, 0, 0);
        expect_at(K_MCNT, 0, 0);
        expect_at(K_PRED, 0, 0);

        step();
        step();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch resolution and prediction controller for the RISC-V core pipeline.
- IF stage: predicts conditional branches with a table of 2-bit saturating counters indexed by PC (BHT).
- EX stage: drives br_un to the branch comparator, resolves the branch from br_eq/br_lt and funct3, detects mispredicts, issues a PC redirect and a multi-cycle pipeline flush, then trains the BHT.
- Keeps branch and mispredict statistics counters for the CSR/MMIO counter block.

Parameters:
BHT_BITS, 6, log2 of BHT entries (64 entries).
FLUSH_CYCLES, 2, cycles flush is held after a mispredict (minimum 1).

Ports:
clk  input  1  core clock
rst  input  1  reset; synchronous, active-high
stall  input  1  pipeline hold; freezes all state updates and suppresses redirect
if_pc  input  32  PC of the instruction in IF
if_pred_taken  output  1  BHT prediction for if_pc
ex_valid  input  1  EX holds a live instruction
ex_is_branch  input  1  EX instruction is a conditional branch (opcode 1100011)
ex_funct3  input  3  branch funct3
ex_pc  input  32  PC of the EX instruction
ex_target  input  32  computed branch target (pc+imm, from ALU)
ex_pred_taken  input  1  prediction carried down the pipe with the instruction
br_eq  input  1  from branch comparator
br_lt  input  1  from branch comparator
br_un  output  1  unsigned-compare select to branch comparator
redirect  output  1  PC mux must load redirect_pc this cycle
redirect_pc  output  32  corrected fetch PC
flush  output  1  kill younger instructions in IF/ID
cnt_clr  input  1  synchronous clear of both statistics counters
branch_cnt  output  32  resolved conditional branches
mispred_cnt  output  32  mispredicted branches

Behaviour:
- br_un: combinational. It is 1 when ex_funct3 is 110 (BLTU) or 111 (BGEU), else 0.
- actual_taken: decoded from funct3:
  - 000 → br_eq
  - 001 → !br_eq
  - 100 and 110 → br_lt
  - 101 and 111 → !br_lt
  - 010 and 011 are illegal; the instruction is not a branch.
- resolve = ex_valid & ex_is_branch & legal funct3 & !stall & (state==IDLE).
- mispredict = resolve & (actual_taken != ex_pred_taken).
- redirect: combinational, equals mispredict.
- redirect_pc: ex_target if actual_taken, else ex_pc+4 (32-bit wrap at 0xFFFFFFFC → 0x00000000).
- FSM with states IDLE and FLUSH, plus a flush counter.
  - IDLE: mispredict moves to FLUSH with fcnt = FLUSH_CYCLES-1. If FLUSH_CYCLES==1, stay in IDLE.
  - FLUSH: if !stall, decrement fcnt. On fcnt==0 and !stall, return to IDLE.
  - stall holds both state and fcnt.
- flush = mispredict | (state==FLUSH). Asserted for exactly FLUSH_CYCLES unstalled cycles, starting the mispredict cycle.
- While in FLUSH, EX inputs are ignored: no resolve, no redirect, no BHT or counter update.
- BHT:
  - 2^BHT_BITS entries of 2 bits each. Index is pc[BHT_BITS+1:2].
  - Reset value of every entry is 01 (weakly not-taken).
  - if_pred_taken = bht[if_pc index][1], combinational.
  - Update on resolve, at the next clk edge: saturating increment if actual_taken (caps at 11), else saturating decrement (floors at 00).
  - Read and write of the same index in the same cycle: the read returns the pre-update value; no bypass.
- Statistics counters:
  - branch_cnt increments on resolve.
  - mispred_cnt increments on mispredict.
  - Both wrap modulo 2^32.
  - cnt_clr takes priority over a same-cycle increment; the result is 0.
- Reset values:
  - state=IDLE, fcnt=0, all BHT entries 01, branch_cnt=0, mispred_cnt=0.
  - Combinational outputs follow their inputs.
  - A reset asserted mid-FLUSH deasserts flush on the following cycle, unless a new mispredict arrives.

Decomposition:
- Shared core package (branch_defs): funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU, BHT counter encodings SNT=00 / WNT=01 / WT=10 / ST=11, FSM state encodings.
- One natural sub-module: bht_2bit. It holds the counter array, async read port and sync saturating update port, parameterised by BHT_BITS.

Test Plan:
1. Reset, then if_pc=0x100 → if_pred_taken=0; all counters 0; flush=0.
2. BLTU, ex_pred_taken=0, br_lt=1 (comparator fed 0x1 vs 0xFFFFFFFF) → br_un=1; redirect=1; redirect_pc=ex_target=0x200; flush high for 2 cycles; branch_cnt=1, mispred_cnt=1; bht[0x100 index]=10.
3. Same-PC BEQ resolved taken three more times → counter saturates at 11. Then one not-taken → 10 and if_pred_taken still 1.
4. BNE, ex_pc=0x3C, pred 1, br_eq=1 → redirect_pc=0x40. A second branch in EX on the next cycle (FLUSH) is ignored: no count, no redirect.
5. stall=1 during a mispredicting BGE → no redirect or updates. Stall released → redirect fires then. Stall in FLUSH extends flush by the stall length.
6. funct3=010 with ex_is_branch=1 → no redirect, no count. cnt_clr coincident with a resolve → both counters read 0. rst during FLUSH → flush=0 next cycle.
